// File: rtl/fsm_job_dispatcher.sv
// ---------------------------------------------------------------------------
// fsm_job_dispatcher
//
// Runs a batch of up to 15 jobs against a single worker. Each job is started
// with a one-cycle go pulse. The worker answers with a one-cycle done pulse.
// A short idle gap separates a done from the next go. A worker that never
// answers within TIMEOUT cycles parks the dispatcher in an error state until
// abort is seen.
//
// Parameters
//   TIMEOUT     maximum cycles spent waiting for done (2..255)
//   GAP_CYCLES  idle cycles between an accepted done and the next go (1..15)
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   start           run a batch; only looked at while idle
//   num_jobs[3:0]   batch size, captured together with start
//   abort           cancel the running batch, or clear an error
//   done            worker completion pulse; only looked at while waiting
//   go              one-cycle job request to the worker
//   busy            batch in progress (issue/wait/gap/finish)
//   complete        one-cycle pulse when a batch finishes normally
//   timeout_err     high while parked in the error state
//   jobs_completed  done responses accepted in the current or last batch
//
// Every output is a flop loaded from the next-state value. That keeps the
// outputs glitch-free, with no combinational path from any input. It also
// lets the asynchronous reset drop them at once.
// ---------------------------------------------------------------------------
module fsm_job_dispatcher #(
    parameter int unsigned TIMEOUT    = 32,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] num_jobs,
    input  logic       abort,
    input  logic       done,
    output logic       go,
    output logic       busy,
    output logic       complete,
    output logic       timeout_err,
    output logic [3:0] jobs_completed
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4,
        ERROR  = 3'd5
    } state_t;

    // Last timer value allowed in WAIT. Reaching it without a done means
    // WAIT has already lasted TIMEOUT cycles.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] TIMER_MAX  = 8'hFF;
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    state_t     state_reg;
    state_t     state_next;

    logic [7:0] timer_reg;
    logic [3:0] gap_reg;
    logic [3:0] target_reg;
    logic [3:0] count_reg;

    logic       go_reg;
    logic       busy_reg;
    logic       complete_reg;
    logic       err_reg;

    // A done accepted in WAIT. abort outranks done. The count is also held
    // at target so it can never wrap, even if target were somehow already
    // reached.
    logic       count_inc;
    logic       last_job;

    assign count_inc = (state_reg == WAIT) && done && !abort &&
                       (count_reg != target_reg);
    assign last_job  = ((count_reg + 4'd1) == target_reg);

    // -----------------------------------------------------------------------
    // Next-state decision
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                // abort and done are meaningless here; only start matters.
                if (start) begin
                    state_next = (num_jobs != 4'd0) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                state_next = abort ? IDLE : WAIT;
            end
            WAIT: begin
                // Priority: abort, then done, then timeout. A done in the
                // final allowed cycle still counts.
                if (abort) begin
                    state_next = IDLE;
                end else if (done) begin
                    state_next = last_job ? FINISH : GAP;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = ERROR;
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (gap_reg == GAP_LAST) begin
                    state_next = ISSUE;
                end
            end
            FINISH: begin
                // complete is already high for this cycle. An abort seen
                // here changes nothing because the batch is over either way.
                state_next = IDLE;
            end
            ERROR: begin
                if (abort) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, datapath and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            timer_reg    <= 8'd0;
            gap_reg      <= 4'd0;
            target_reg   <= 4'd0;
            count_reg    <= 4'd0;
            go_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            complete_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;

            // Outputs follow the state being entered, so each one is valid
            // for exactly the cycles spent in the matching state.
            go_reg       <= (state_next == ISSUE);
            busy_reg     <= (state_next inside {ISSUE, WAIT, GAP, FINISH});
            complete_reg <= (state_next == FINISH);
            err_reg      <= (state_next == ERROR);

            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        target_reg <= num_jobs;
                        count_reg  <= 4'd0;
                    end
                end
                ISSUE: begin
                    timer_reg <= 8'd0;
                end
                WAIT: begin
                    if (timer_reg != TIMER_MAX) begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                    if (count_inc) begin
                        count_reg <= count_reg + 4'd1;
                    end
                    // Any exit to GAP starts the gap count from zero.
                    gap_reg <= 4'd0;
                end
                GAP: begin
                    if (gap_reg != GAP_LAST) begin
                        gap_reg <= gap_reg + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign go             = go_reg;
    assign busy           = busy_reg;
    assign complete       = complete_reg;
    assign timeout_err    = err_reg;
    assign jobs_completed = count_reg;

endmodule

// File: tb/tb_fsm_job_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_fsm_job_dispatcher
//
// The bench drives a worker that answers each go with done D cycles later.
// D = 0 means the worker never answers. The bench predicts each batch as a
// timeline of event cycles: go cycles, done cycles, the complete cycle and
// the error entry cycle. Each timeline is worked out with plain arithmetic
// from the job delays, and is then cut short at any abort. A monitor logs
// the events the DUT actually produces, and the two are compared per batch.
// Cycle n is the interval after the n-th rising edge. Outputs are sampled
// on the falling edge. Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_fsm_job_dispatcher;

    localparam int TIMEOUT = 32;
    localparam int GAP     = 1;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] num_jobs;
    logic       abort;
    logic       done;
    logic       go;
    logic       busy;
    logic       complete;
    logic       timeout_err;
    logic [3:0] jobs_completed;

    logic       wdone;
    logic       sdone;
    assign done = wdone | sdone;

    fsm_job_dispatcher #(
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_jobs       (num_jobs),
        .abort          (abort),
        .done           (done),
        .go             (go),
        .busy           (busy),
        .complete       (complete),
        .timeout_err    (timeout_err),
        .jobs_completed (jobs_completed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Worker state
    int dly_a[16];
    int dly_q[$];
    int due_q[$];

    // Observed events
    int go_log[$];
    int cmp_log[$];
    int err_first  = -1;
    int err_last   = -1;
    int busy_first = -1;
    int busy_last  = -1;
    int busy_cnt   = 0;

    // Expected events
    int exp_go[$];
    int exp_cmp;
    int exp_cnt;
    int exp_err_first;
    int exp_err_last;
    int exp_busy_last;
    int exp_busy_end;
    int a_eff;
    int end_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        go_log.delete();
        cmp_log.delete();
        err_first  = -1;
        err_last   = -1;
        busy_first = -1;
        busy_last  = -1;
        busy_cnt   = 0;
    endtask

    // Monitor: log what the DUT does in each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (go === 1'b1) go_log.push_back(cyc);
            if (complete === 1'b1) cmp_log.push_back(cyc);
            if (timeout_err === 1'b1) begin
                if (err_first < 0) err_first = cyc;
                err_last = cyc;
            end
            if (busy === 1'b1) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
                busy_cnt++;
            end
        end
    end

    // Worker: take the next delay when a go is seen and schedule the done.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (go === 1'b1 && dly_q.size() > 0) begin
                d = dly_q.pop_front();
                if (d > 0) due_q.push_back(cyc + d);
            end
        end
    end

    initial begin
        wdone = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                wdone = 1'b1;
                void'(due_q.pop_front());
            end else begin
                wdone = 1'b0;
            end
        end
    end

    // Build the event timeline of a batch that starts in cycle s. A negative
    // a_in means there is no random abort. An error then gets an abort three
    // cycles after it is entered.
    task automatic model(input int s, input int n, input int a_in);
        int t;
        int d;
        int c_full;
        int e_full;
        int dn[$];
        exp_go.delete();
        t      = s + 1;
        c_full = -1;
        e_full = -1;
        if (n == 0) c_full = s + 1;
        for (int i = 0; i < n; i++) begin
            exp_go.push_back(t);
            d = dly_a[i];
            if (d >= 1 && d <= TIMEOUT) begin
                dn.push_back(t + d);
                if (dn.size() == n) begin
                    c_full = t + d + 1;
                    break;
                end
                t = t + d + 1 + GAP;
            end else begin
                e_full = t + 1 + TIMEOUT;
                break;
            end
        end
        exp_busy_end = (c_full >= 0) ? c_full : e_full - 1;
        a_eff = a_in;
        if (e_full >= 0 && a_eff < 0) a_eff = e_full + 3;
        if (a_eff >= 0) begin
            while (exp_go.size() > 0 && exp_go[exp_go.size()-1] > a_eff) void'(exp_go.pop_back());
            exp_cnt = 0;
            foreach (dn[k]) if (dn[k] < a_eff) exp_cnt++;
            exp_cmp = (c_full >= 0 && c_full <= a_eff) ? c_full : -1;
            if (e_full >= 0 && e_full <= a_eff) begin
                exp_err_first = e_full;
                exp_err_last  = a_eff;
            end else begin
                exp_err_first = -1;
                exp_err_last  = -1;
            end
            exp_busy_last = (exp_busy_end < a_eff) ? exp_busy_end : a_eff;
        end else begin
            exp_cnt       = dn.size();
            exp_cmp       = c_full;
            exp_err_first = -1;
            exp_err_last  = -1;
            exp_busy_last = exp_busy_end;
        end
        end_cyc = ((exp_busy_end + 1 > a_eff) ? exp_busy_end + 1 : a_eff) + 2;
    endtask

    // mode: -1 no abort, -2 random abort inside the batch, >=0 abort at s+mode.
    // Call this task 1 time unit after a rising edge. start is driven in the
    // current cycle.
    task automatic run_batch(input int n, input int mode, input bit noise);
        int s;
        int a_in;
        int g;
        clear_logs();
        dly_q.delete();
        for (int i = 0; i < n; i++) dly_q.push_back(dly_a[i]);
        s = cyc;
        model(s, n, -1);
        if (mode == -1) a_in = -1;
        else if (mode == -2) a_in = s + 1 + int'($urandom_range(0, 32'(exp_busy_end - s - 1)));
        else a_in = s + mode;
        model(s, n, a_in);
        start    = 1'b1;
        num_jobs = 4'(n);
        while (cyc < end_cyc) begin
            step();
            abort = (cyc == a_eff);
            if (noise && cyc <= exp_busy_last) begin
                start    = ($urandom_range(0, 5) == 0);
                num_jobs = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        g = 0;
        while (due_q.size() > 0 && g < 100) begin
            step();
            g++;
        end
        chk("worker_drain", 32'(due_q.size()), 32'd0);
        step();
        step();
        @(negedge clk);
        chk("go_count", 32'(go_log.size()), 32'(exp_go.size()));
        for (int i = 0; i < go_log.size() && i < exp_go.size(); i++)
            chk($sformatf("go%0d_cycle", i), 32'(go_log[i] - s), 32'(exp_go[i] - s));
        chk("complete_count", 32'(cmp_log.size()), (exp_cmp >= 0) ? 32'd1 : 32'd0);
        if (cmp_log.size() > 0 && exp_cmp >= 0)
            chk("complete_cycle", 32'(cmp_log[0] - s), 32'(exp_cmp - s));
        chk("err_first", (err_first < 0) ? -32'sd1 : 32'(err_first - s),
            (exp_err_first < 0) ? -32'sd1 : 32'(exp_err_first - s));
        chk("err_last", (err_last < 0) ? -32'sd1 : 32'(err_last - s),
            (exp_err_last < 0) ? -32'sd1 : 32'(exp_err_last - s));
        chk("jobs_completed", 32'(jobs_completed), 32'(exp_cnt));
        chk("busy_first", 32'(busy_first - s), 32'd1);
        chk("busy_last", 32'(busy_last - s), 32'(exp_busy_last - s));
        chk("busy_cnt", 32'(busy_cnt), 32'(exp_busy_last - s));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_timeout_err", 32'(timeout_err), 32'd0);
        $display("[TB] batch n=%0d start=%0d abort_at=%0d gos=%0d completes=%0d err_at=%0d jobs=%0d",
                 n, s, a_eff, go_log.size(), cmp_log.size(), err_first, jobs_completed);
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_go"}, 32'(go), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_complete"}, 32'(complete), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_jobs"}, 32'(jobs_completed), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n;
        int p;
        rst      = 1'b0;
        start    = 1'b0;
        num_jobs = 4'd0;
        abort    = 1'b0;
        sdone    = 1'b0;

        // Reset state, checked before any clock edge.
        #1 rst = 1'b1;
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three jobs at D=16. start is in the first cycle after release.
        for (int i = 0; i < 3; i++) dly_a[i] = 16;
        run_batch(3, -1, 1'b0);

        // Spurious done while idle.
        clear_logs();
        sdone = 1'b1;
        step();
        sdone = 1'b0;
        step();
        @(negedge clk);
        chk("idle_done_jobs", 32'(jobs_completed), 32'(exp_cnt));
        chk("idle_done_go", 32'(go_log.size()), 32'd0);
        step();

        // Empty batch, with start noise during the busy cycle.
        run_batch(0, -1, 1'b1);

        // Worker never answers, so the batch times out and is then aborted.
        dly_a[0] = 0;
        dly_a[1] = 0;
        run_batch(2, -1, 1'b0);

        // done on the last allowed WAIT cycle is counted. One cycle later
        // is too late.
        dly_a[0] = TIMEOUT;
        dly_a[1] = TIMEOUT;
        run_batch(2, -1, 1'b0);
        dly_a[0] = TIMEOUT + 1;
        run_batch(1, -1, 1'b0);

        // Abort in WAIT of job 2 of 4. The late done for job 2 lands in IDLE.
        for (int i = 0; i < 4; i++) dly_a[i] = 10;
        run_batch(4, 18, 1'b0);

        // Full-size batch with start noise.
        for (int i = 0; i < 15; i++) dly_a[i] = 1;
        run_batch(15, -1, 1'b1);

        // Reset during GAP.
        clear_logs();
        dly_q.delete();
        for (int i = 0; i < 3; i++) dly_q.push_back(5);
        s = cyc;
        start    = 1'b1;
        num_jobs = 4'd3;
        step();
        start = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("gap_busy", 32'(busy), 32'd1);
        chk("gap_go", 32'(go), 32'd0);
        chk("gap_jobs", 32'(jobs_completed), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("rst_in_gap");
        dly_q.delete();
        due_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        dly_a[0] = 3;
        dly_a[1] = 3;
        run_batch(2, -1, 1'b0);

        // Reset while go is high. go must drop before any clock edge.
        clear_logs();
        dly_q.delete();
        dly_q.push_back(5);
        start    = 1'b1;
        num_jobs = 4'd1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("issue_go", 32'(go), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk_all_zero("rst_in_issue");
        dly_q.delete();
        due_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        dly_a[0] = 7;
        run_batch(1, -1, 1'b0);

        // Random batches.
        for (int r = 0; r < 25; r++) begin
            n = ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 8));
            for (int i = 0; i < 16; i++) begin
                p = int'($urandom_range(0, 19));
                if (p == 0) dly_a[i] = 0;
                else if (p == 1) dly_a[i] = int'($urandom_range(30, 34));
                else dly_a[i] = int'($urandom_range(1, 20));
            end
            run_batch(n, ($urandom_range(0, 3) == 0) ? -2 : -1, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
